// File: rtl/io_pkg.sv
// io_pkg: register offsets and STATUS bit positions shared by io_bridge.
//   No ports; imported by io_bridge and the bench.
package io_pkg;

   localparam logic [7:0] IO_TXDATA = 8'h00;
   localparam logic [7:0] IO_RXDATA = 8'h01;
   localparam logic [7:0] IO_STATUS = 8'h02;
   localparam logic [7:0] IO_TIMER  = 8'h03;

   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_FULL  = 2;
   localparam int ST_TX_OVF   = 3;

endpackage

// File: rtl/io_fifo.sv
// io_fifo: synchronous FIFO with count-based full/empty, async active-low reset.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_push/i_data : write request and data (accepted when not full, or full with a pop)
//   i_pop         : read request (ignored while empty)
//   o_data        : head entry, 0 while empty
//   o_full/o_empty: occupancy flags
module io_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_cnt;
   logic          w_push;
   logic          w_pop;

   assign o_empty = r_cnt == '0;
   assign o_full  = r_cnt == (AW+1)'(DEPTH);
   assign w_pop   = i_pop && !o_empty;
   // a pop frees the slot the push lands in, so full+pop still accepts
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_data  = o_empty ? '0 : r_mem[r_rd];

   always_ff @(posedge clk)
      if (w_push) r_mem[r_wr] <= i_data;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop) r_rd <= r_rd + 1'b1;
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end

endmodule

// File: rtl/io_bridge.sv
// io_bridge: CPU-to-SRAM bridge with a 256-word I/O page (TX FIFO, RX register, STATUS, timer).
//   clk, rst_n                  : clock, asynchronous active-low reset
//   address, wdata, rdata       : CPU bus (rdata is combinational)
//   wren_n, oen_n               : CPU write/read strobes, active-low
//   mem_rdata, mem_wren_n/oen_n : SRAM side, strobes blocked for the I/O page and in reset
//   tx_data/valid/ready         : transmit stream from the TX FIFO
//   rx_data/valid/ready         : receive stream into the holding register
//   Define IO_TIMER_EN to build the free-running 16-bit timer at offset 0x03.
module io_bridge
   import io_pkg::*;
#(
   parameter logic [15:0] IO_BASE  = 16'hFF00,
   parameter int          TX_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] address,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   input  logic        wren_n,
   input  logic        oen_n,
   input  logic [15:0] mem_rdata,
   output logic        mem_wren_n,
   output logic        mem_oen_n,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   logic        w_io_sel;
   logic [7:0]  w_off;
   logic        w_wr_new;
   logic        w_rd_new;
   logic        w_tx_push;
   logic        w_tx_pop;
   logic        w_tx_full;
   logic        w_tx_empty;
   logic        w_rx_pop;
   logic        w_ovf_clr;
   logic [15:0] w_status;
   logic [15:0] w_timer;
   logic [15:0] w_reg;

   logic        r_prev_wr;
   logic        r_prev_rd;
   logic [15:0] r_prev_addr;
   logic        r_rx_full;
   logic [7:0]  r_rx_byte;
   logic        r_tx_ovf;

   assign w_io_sel = address[15:8] == IO_BASE[15:8];
   assign w_off    = address[7:0];

   // a held strobe at an unchanged address is the same access; only its first cycle acts
   assign w_wr_new = !wren_n && !(r_prev_wr && r_prev_addr == address);
   assign w_rd_new = !oen_n && !(r_prev_rd && r_prev_addr == address);

   assign w_tx_push = w_io_sel && w_wr_new && w_off == IO_TXDATA;
   assign w_tx_pop  = tx_valid && tx_ready;
   assign w_rx_pop  = w_io_sel && w_rd_new && w_off == IO_RXDATA && r_rx_full;
   assign w_ovf_clr = w_io_sel && w_wr_new && w_off == IO_STATUS && wdata[ST_TX_OVF];

   assign tx_valid   = !w_tx_empty;
   assign rx_ready   = !r_rx_full;
   assign mem_wren_n = !rst_n || w_io_sel || wren_n;
   assign mem_oen_n  = !rst_n || w_io_sel || oen_n;

   always_comb begin
      w_status = '0;
      w_status[ST_TX_FULL]  = w_tx_full;
      w_status[ST_TX_EMPTY] = w_tx_empty;
      w_status[ST_RX_FULL]  = r_rx_full;
      w_status[ST_TX_OVF]   = r_tx_ovf;
   end

   assign w_reg = w_off == IO_RXDATA ? {8'h00, r_rx_byte} :
                  w_off == IO_STATUS ? w_status :
                  w_off == IO_TIMER  ? w_timer : 16'h0000;

   assign rdata = !w_io_sel ? mem_rdata : oen_n ? 16'h0000 : w_reg;

   io_fifo #(.W(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_tx_push),
      .i_data  (wdata[7:0]),
      .i_pop   (tx_ready),
      .o_data  (tx_data),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_prev_wr   <= 1'b0;
         r_prev_rd   <= 1'b0;
         r_prev_addr <= '0;
         r_rx_full   <= 1'b0;
         r_rx_byte   <= '0;
         r_tx_ovf    <= 1'b0;
      end else begin
         r_prev_wr   <= !wren_n;
         r_prev_rd   <= !oen_n;
         r_prev_addr <= address;
         r_tx_ovf    <= (r_tx_ovf && !w_ovf_clr) || (w_tx_push && w_tx_full && !w_tx_pop);
         // pop needs rx_full and capture needs !rx_full, so they never collide
         if (w_rx_pop) r_rx_full <= 1'b0;
         else if (rx_valid && !r_rx_full) begin
            r_rx_full <= 1'b1;
            r_rx_byte <= rx_data;
         end
      end

`ifdef IO_TIMER_EN
   logic [15:0] r_timer;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_timer <= '0;
      else r_timer <= (w_io_sel && w_wr_new && w_off == IO_TIMER) ? wdata : r_timer + 16'd1;

   assign w_timer = r_timer;
`else
   logic w_unused;

   assign w_timer  = 16'h0000;
   assign w_unused = ^wdata[15:8];
`endif

endmodule

// File: doc/io_bridge.md
# io_bridge

Memory-side bus bridge sitting directly downstream of `cpu`, between the CPU's single-cycle memory bus and the external SRAM. Decodes one 256-word I/O page, steers all other accesses unchanged to SRAM, and implements memory-mapped peripherals:
- an 8-bit transmit stream fed through a FIFO,
- an 8-bit receive holding register,
- a status register,
- an optional free-running timer.

Read data is combinational, so `cpu` samples it in the same cycle it drives `oen_n` low.

## Interface
- `IO_BASE`, 16'hFF00: I/O page base; only bits [15:8] are compared.
- `TX_DEPTH`, 8: TX FIFO entries; power of two, 2..64.

- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `address` in 16: CPU address.
- `wdata` in 16: CPU write data (cpu `data_out`).
- `rdata` out 16: read data to cpu `data_in`.
- `wren_n` in 1: CPU write strobe, active-low.
- `oen_n` in 1: CPU read strobe, active-low.
- `mem_rdata` in 16: SRAM read data.
- `mem_wren_n` out 1: SRAM write strobe.
- `mem_oen_n` out 1: SRAM output enable.
- `tx_data` out 8: transmit byte.
- `tx_valid` out 1: transmit byte valid.
- `tx_ready` in 1: sink accepts.
- `rx_data` in 8: receive byte.
- `rx_valid` in 1: receive byte valid.
- `rx_ready` out 1: bridge accepts.

## Operation
- `io_sel` is true when `address[15:8] == IO_BASE[15:8]`.
  - When `io_sel` is set, `mem_wren_n` and `mem_oen_n` are forced to 1.
  - Otherwise both are passed through from `wren_n` and `oen_n`.
  - While `rst_n` is low, both are forced to 1.
- `rdata` is selected as follows:
  - `io_sel` with `oen_n` low: register mux.
  - `io_sel` with `oen_n` high: 0.
  - Otherwise: `mem_rdata`.
- Side effects fire only on the first cycle of a strobe run. A strobe is a new access if the previous cycle did not have the same strobe low at the same address.
- Register map, by offset within the I/O page:
  - 0x00 TXDATA, write: push `wdata[7:0]`. If the FIFO is full with no simultaneous pop, the byte is dropped and sticky `tx_ovf` is set. Reads return 0.
  - 0x01 RXDATA, read: returns `{8'h00, rx_byte}`. If `rx_full` is set, clears it (pop). If `rx_full` is clear, returns the last byte with no state change.
  - 0x02 STATUS, read: bit0 `tx_full`, bit1 `tx_empty`, bit2 `rx_full`, bit3 `tx_ovf`, bits [15:4] read 0. Writing with `wdata[3]=1` clears `tx_ovf`.
  - 0x03 TIMER: see Configuration.
  - Any other offset: reads return 0, writes are ignored.
- TX FIFO:
  - `tx_valid` = FIFO not empty.
  - `tx_data` = FIFO head.
  - A pop occurs when `tx_valid && tx_ready`.
  - A push while full, in the same cycle as a pop, is accepted; the count is unchanged.
  - Read and write pointers are log2(`TX_DEPTH`) bits and wrap naturally. An extra count bit distinguishes full from empty.
- RX:
  - `rx_ready` = !`rx_full`.
  - On `rx_valid && rx_ready`, capture `rx_data` and set `rx_full`.
  - A CPU pop in the same cycle as an RX arrival cannot coincide with a capture, because `rx_ready` is 0 while full. The capture happens on a later cycle.
- Reset values, applied asynchronously:
  - FIFO empty; `tx_valid` 0; `tx_data` 0.
  - `rx_full` 0, so `rx_ready` 1; `rx_byte` 0.
  - `tx_ovf` 0; timer 0.
  - Edge-detect history cleared, so the first strobe after reset counts as new.
- Reset mid-operation discards FIFO contents and any pending RX byte.

## Timing
- `rdata`: combinational from `address`, `oen_n`, and registers, with zero-cycle latency. Valid in the same cycle the CPU samples it.
- Push, pop, and status changes take effect at the next rising `clk`. A STATUS read in the same cycle as a push shows the pre-push state.
- CPU write to TXDATA at edge N: `tx_valid` is high after edge N and the byte is presentable from cycle N+1.
- RX capture at edge N: STATUS bit2 reads 1 from cycle N+1.
- `tx_valid` must not depend combinationally on `tx_ready`.
- Once `tx_valid` is high, it and `tx_data` stay stable until the handshake completes.

## Configuration
- `IO_TIMER_EN` defined:
  - Offset 0x03 holds a 16-bit counter that increments every cycle and wraps 0xFFFF to 0x0000.
  - Reads return the current value.
  - A write loads `wdata`; the next cycle reads exactly `wdata`, with no increment that cycle.
- `IO_TIMER_EN` undefined: no counter flops exist, offset 0x03 reads 0, and writes to it are ignored.

## Structure
- Package `io_pkg` holds:
  - offset constants `IO_TXDATA`, `IO_RXDATA`, `IO_STATUS`, `IO_TIMER`;
  - status bit positions `ST_TX_FULL`, `ST_TX_EMPTY`, `ST_RX_FULL`, `ST_TX_OVF`.
- Sub-module `io_fifo`: a parameterised synchronous FIFO (width, depth) with push/pop, full/empty, and async active-low reset. Used for TX.
- Decode, edge detect, RX register, STATUS, and timer live in `io_bridge`.

## Test plan
- Post-reset read of STATUS (0xFF02) returns 0x0002; `rx_ready`=1, `tx_valid`=0, `mem_oen_n`=`mem_wren_n`=1 during reset.
- Write 0x0041 to 0xFF00 with `tx_ready`=0 → `tx_valid`=1, `tx_data`=0x41. Then raise `tx_ready` for 1 cycle → `tx_valid`=0 and STATUS=0x0002.
- Push 9 bytes with `tx_ready`=0 and `TX_DEPTH`=8 → STATUS=0x0009. Write 0x0008 to 0xFF02 → STATUS=0x0001. Draining yields exactly the first 8 bytes in order.
- Drive `rx_data`=0x5A with `rx_valid` for 1 cycle → `rx_ready`=0 and STATUS bit2=1. Holding `oen_n` low at 0xFF01 for 3 cycles returns 0x005A throughout, pops once, then `rx_ready`=1.
- Read 0x1234 with `mem_rdata`=0xBEEF → `rdata`=0xBEEF and `mem_oen_n`=0. Writes to 0xFF10 keep `mem_wren_n`=1 and change no state.
- With `IO_TIMER_EN`, write 0xFFFE to 0xFF03 → subsequent reads return 0xFFFE, 0xFFFF, 0x0000. Without the macro, reads return 0.
